// File: rtl/wb_master_cmd_if.sv
// rtl/wb_master_cmd_if.sv - Wishbone B3 classic bus interface
interface wishbone_b3 #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m2s;
    logic [DATA_WIDTH-1:0]   dat_s2m;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    lock;

    modport master (
        output adr, dat_m2s, sel, we, cyc, stb, cti, bte, lock,
        input  dat_s2m, ack, err, rty
    );

    modport slave (
        input  adr, dat_m2s, sel, we, cyc, stb, cti, bte, lock,
        output dat_s2m, ack, err, rty
    );
endinterface

// File: rtl/wb_master_cmd.sv
// rtl/wb_master_cmd.sv - single-transfer Wishbone B3 master with retry backoff and timeout
module wb_master_cmd #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_GAP      = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [1:0]              resp_status,
    output logic                    busy,
    wishbone_b3.master              bus
);
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GP_W = $clog2(RETRY_GAP + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(RETRY_GAP - 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_RETRY   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    cyc_q, cyc_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              status_q, status_d;
    logic [RT_W-1:0]         retry_q, retry_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic [GP_W-1:0]         gap_q, gap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            cyc_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            status_q <= ST_OK;
            retry_q  <= '0;
            to_q     <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            cyc_q    <= cyc_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            retry_q  <= retry_d;
            to_q     <= to_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        retry_d  = retry_q;
        to_d     = to_q;
        gap_d    = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    we_d     = cmd_we;
                    adr_d    = cmd_adr;
                    dat_d    = cmd_dat;
                    sel_d    = cmd_sel;
                    rdata_d  = '0;
                    status_d = ST_OK;
                    retry_d  = '0;
                    to_d     = '0;
                    state_d  = S_BUS;
                end
            end
            S_BUS: begin
                // err wins over a simultaneous ack, and ack over rty
                if (bus.err) begin
                    status_d = ST_ERR;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end else if (bus.ack) begin
                    status_d = ST_OK;
                    rdata_d  = we_q ? '0 : bus.dat_s2m;
                    state_d  = S_RESP;
                end else if (bus.rty) begin
                    if (retry_q < RT_MAX) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        status_d = ST_RETRY;
                        rdata_d  = '0;
                        state_d  = S_RESP;
                    end
                end else if (TO_EN) begin
                    if (to_q == TO_LAST) begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        state_d  = S_RESP;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GP_LAST) begin
                    to_d    = '0;
                    state_d = S_BUS;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered outputs follow the next state so cyc drops on the edge that leaves BUS
        cyc_d   = (state_d == S_BUS);
        valid_d = (state_d == S_RESP);
        ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        cmd_ready   = ready_q;
        resp_valid  = valid_q;
        resp_rdata  = rdata_q;
        resp_status = status_q;
        busy        = (state_q != S_IDLE);
    end

    assign bus.adr     = adr_q;
    assign bus.dat_m2s = dat_q;
    assign bus.sel     = sel_q;
    assign bus.we      = we_q;
    assign bus.cyc     = cyc_q;
    assign bus.stb     = cyc_q;
    assign bus.cti     = 3'b000;
    assign bus.bte     = 2'b00;
    assign bus.lock    = 1'b0;
endmodule

// File: tb/tb_wb_master_cmd.sv
// tb/tb_wb_master_cmd.sv - scoreboard bench for wb_master_cmd against a behavioural slave
module tb_wb_master_cmd;
    localparam int M_REG    = 0;
    localparam int M_RTYK   = 1;
    localparam int M_RTY    = 2;
    localparam int M_ERRACK = 3;
    localparam int M_NONE   = 4;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic        busy;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    time         hs_time;

    int          slv_mode = M_REG;
    int          rty_k    = 0;
    int          att      = 0;
    logic [31:0] sreg     = 32'h0;

    int          rises  = 0;
    int          hi_run = 0;
    int          lo_run = 0;
    int          last_hi = 0;
    logic        prev_cyc = 1'b0;
    int          gaps[$];

    wishbone_b3 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus_if ();

    wb_master_cmd dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_status (resp_status),
        .busy        (busy),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    wire sc = bus_if.cyc & bus_if.stb;
    assign bus_if.rty     = sc && ((slv_mode == M_RTYK && att < rty_k) || slv_mode == M_RTY);
    assign bus_if.err     = sc && (slv_mode == M_ERRACK);
    assign bus_if.ack     = sc && (slv_mode == M_REG || slv_mode == M_ERRACK ||
                                   (slv_mode == M_RTYK && att >= rty_k));
    assign bus_if.dat_s2m = sreg;

    function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s, input logic [1:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                case (m)
                    2'd0:    r[i*8 +: 8] = d[i*8 +: 8];
                    2'd1:    r[i*8 +: 8] = old[i*8 +: 8] | d[i*8 +: 8];
                    2'd2:    r[i*8 +: 8] = old[i*8 +: 8] & ~d[i*8 +: 8];
                    default: r[i*8 +: 8] = old[i*8 +: 8] ^ d[i*8 +: 8];
                endcase
            end
        end
        return r;
    endfunction

    // Set/clear register slave: mode from adr[3:2], retry attempts counted per command
    always @(posedge clk) begin
        if (!busy) att <= 0;
        else if (sc && bus_if.rty) att <= att + 1;
        if (sc && bus_if.we && bus_if.ack && !bus_if.err)
            sreg <= apply(sreg, bus_if.dat_m2s, bus_if.sel, bus_if.adr[3:2]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Response monitor plus bus activity tracker
    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_resp: got status %0d rdata 0x%0h, expected no response",
                         resp_status, resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rd);
                chk("resp_status", {30'h0, resp_status}, {30'h0, mon_e.st});
            end
        end
        if (!busy) lo_run = 0;
        if (bus_if.cyc) begin
            if (!prev_cyc) begin
                rises++;
                if (lo_run > 0) gaps.push_back(lo_run);
            end
            hi_run++;
            lo_run = 0;
        end else begin
            if (prev_cyc) last_hi = hi_run;
            hi_run = 0;
            if (busy) lo_run++;
        end
        prev_cyc = bus_if.cyc;
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] erd, input logic [1:0] est,
                         input bit push);
        bit   got;
        exp_t e;
        got = 0;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                got = 1;
                break;
            end
        end
        if (got) begin
            hs_time = $time;
            if (push) begin
                e.rd = erd;
                e.st = est;
                exp_q.push_back(e);
            end
        end else begin
            chk("cmd_handshake", 32'd0, 32'd1);
        end
        #1;
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = 32'hDEAD_BEEF; cmd_dat = 32'h1234_5678; cmd_sel = ~sel;
    endtask

    task automatic wait_resp(output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) got = 1;
            @(posedge clk);
            lat++;
            if (got) break;
        end
        if (!got) chk("resp_wait", 32'd0, 32'd1);
        #1;
    endtask

    initial begin
        int          lat;
        time         t1;
        int          r0;
        int          g0;
        logic [31:0] rd0;
        logic [1:0]  st0;
        bit          stable;
        bit          ready_low;
        bit          seen;

        reset_n = 1'b0; resp_ready = 1'b1; cmd_valid = 1'b0;
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc_stb_we", {29'h0, bus_if.cyc, bus_if.stb, bus_if.we}, 32'h0);
        chk("rst_adr", bus_if.adr, 32'h0);
        chk("rst_dat_m2s", bus_if.dat_m2s, 32'h0);
        chk("rst_sel", {28'h0, bus_if.sel}, 32'h0);
        chk("rst_resp", {28'h0, resp_valid, resp_status, busy}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        // Write / read / clear-mode / byte lanes, all back-to-back
        issue(1'b1, 32'h0, 32'h0000_00A5, 4'hF, 32'h0, 2'd0, 1'b1);
        t1 = hs_time;
        wait_resp(lat);
        chk("min_latency", lat, 32'd2);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_00A5, 2'd0, 1'b1);
        chk("throughput_cycles", int'((hs_time - t1) / 10), 32'd3);
        wait_resp(lat);
        issue(1'b1, 32'h8, 32'h0000_0005, 4'hF, 32'h0, 2'd0, 1'b1);
        wait_resp(lat);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_00A0, 2'd0, 1'b1);
        wait_resp(lat);
        issue(1'b1, 32'h0, 32'h0, 4'hF, 32'h0, 2'd0, 1'b1);
        wait_resp(lat);
        issue(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0010, 32'h0, 2'd0, 1'b1);
        wait_resp(lat);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_FF00, 2'd0, 1'b1);
        wait_resp(lat);

        // Retry recovery: two rty then ack
        slv_mode = M_RTYK; rty_k = 2;
        r0 = rises; g0 = gaps.size();
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_FF00, 2'd0, 1'b1);
        wait_resp(lat);
        chk("retry_latency", lat, 32'd8);
        chk("retry_bus_periods", rises - r0, 32'd3);
        chk("retry_gap_count", gaps.size() - g0, 32'd2);
        if (gaps.size() >= g0 + 2) begin
            chk("retry_gap0", gaps[g0], 32'd2);
            chk("retry_gap1", gaps[g0 + 1], 32'd2);
        end

        // Retry exhaustion
        slv_mode = M_RTY;
        r0 = rises;
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd3, 1'b1);
        wait_resp(lat);
        chk("exhaust_attempts", rises - r0, 32'd4);

        // err together with ack
        slv_mode = M_ERRACK;
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd1, 1'b1);
        wait_resp(lat);

        // Timeout
        slv_mode = M_NONE;
        issue(1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 2'd2, 1'b1);
        wait_resp(lat);
        chk("timeout_cyc_high", last_hi, 32'd255);
        chk("timeout_latency", lat, 32'd256);
        chk("timeout_busy_after", {31'h0, busy}, 32'h0);

        // Backpressure: response held for 10 cycles
        slv_mode = M_REG;
        resp_ready = 1'b0;
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_FF00, 2'd0, 1'b1);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_resp_seen", {31'h0, seen}, 32'h1);
        rd0 = resp_rdata; st0 = resp_status; stable = 1; ready_low = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_status !== st0) stable = 0;
            if (cmd_ready !== 1'b0) ready_low = 0;
        end
        chk("bp_resp_stable", {31'h0, stable}, 32'h1);
        chk("bp_cmd_ready_low", {31'h0, ready_low}, 32'h1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_resp(lat);

        // Reset during BUS: command discarded, no response
        slv_mode = M_NONE;
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("cyc_before_reset", {31'h0, bus_if.cyc}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_cyc_stb", {30'h0, bus_if.cyc, bus_if.stb}, 32'h0);
        chk("reset_busy_valid_ready", {29'h0, busy, resp_valid, cmd_ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_midreset", {31'h0, cmd_ready}, 32'h1);
        repeat (20) @(posedge clk);
        #1;

        slv_mode = M_REG;
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_FF00, 2'd0, 1'b1);
        wait_resp(lat);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/wb_master_cmd.md
# wb_master_cmd

Single-transfer Wishbone B3 master that converts a simple valid/ready command port into classic (non-burst) bus cycles. It drives one `wishbone_b3.master` interface, handles the slave terminations `ack`, `err` and `rty`, and returns read data plus a completion status on a valid/ready response port. Retry backoff and a bus timeout are built in. It sits between a control engine (CPU bridge, init sequencer) and the slave-side register fabric.

## Interface
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- SELECT_WIDTH, 4, number of byte-lane select bits.
- TIMEOUT_CYCLES, 255, bus cycles allowed per attempt before abort. 0 disables the timeout.
- MAX_RETRIES, 3, number of re-issues allowed after `rty`.
- RETRY_GAP, 2, idle cycles with `cyc` low between a `rty` and the re-issue. Must be at least 1.
- clk  in  1  single clock. All state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADDR_WIDTH  byte address, passed unmodified to bus.adr.
- cmd_dat  in  DATA_WIDTH  write data.
- cmd_sel  in  SELECT_WIDTH  byte-lane selects.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  DATA_WIDTH  read data. 0 for writes and for failed reads.
- resp_status  out  2  0 = OK, 1 = ERR, 2 = TIMEOUT, 3 = RETRY_EXHAUSTED.
- busy  out  1  high in any state other than IDLE.
- bus  wishbone_b3.master  -  drives adr, dat_m2s, sel, we, cyc, stb; samples dat_s2m, ack, err, rty. Any other interface outputs are tied to 0.

## Operation
- FSM states: IDLE, BUS, GAP, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On a cmd_valid & cmd_ready handshake: register we/adr/dat/sel, clear the retry and timeout counters, go to BUS.
- **BUS**
  - cyc = stb = 1. adr, dat_m2s, sel and we come from the registered command.
  - Termination is sampled each edge with priority err > ack > rty:
    - err: status 1, go to RESP.
    - ack: status 0. On a read, capture dat_s2m into resp_rdata. Go to RESP.
    - rty with retry count < MAX_RETRIES: increment the retry count, go to GAP.
    - rty with retry count = MAX_RETRIES: status 3, go to RESP.
  - Timeout: with no termination, the timeout counter increments each edge. When it reaches TIMEOUT_CYCLES, set status 2 and go to RESP.
- **GAP**
  - cyc = stb = 0.
  - Count RETRY_GAP edges, then return to BUS. The timeout counter is cleared on re-entry to BUS.
- **RESP**
  - resp_valid = 1. resp_rdata and resp_status are held stable.
  - On resp_ready, go to IDLE.
  - cmd_ready = 0.
- cyc and stb drop on the same edge that leaves BUS, so a slave never sees stb without cyc.
- All bus outputs are registered. There is no combinational path from cmd_* to bus.*, nor from bus.* to resp_*.
- Counter widths: $clog2(TIMEOUT_CYCLES+1), $clog2(MAX_RETRIES+1), $clog2(RETRY_GAP+1). No wrap-around is possible.

## Timing
- **Reset values** (applied immediately while reset_n is low):
  - cyc, stb, we = 0; adr, dat_m2s, sel = 0.
  - resp_valid = 0, resp_rdata = 0, resp_status = 0, busy = 0.
  - cmd_ready = 0 while reset_n is low, then 1 from the first cycle after release.
- **Reset mid-cycle:** cyc and stb fall asynchronously and the in-flight command is discarded. No response is ever produced for it.
- **Latency**, for a command handshake at edge N:
  - cyc/stb are high during cycle N+1.
  - A slave with combinational ack is sampled at edge N+2.
  - resp_valid is high from N+2.
  - The minimum command-to-response time is 2 cycles.
- Each wait-state cycle (ack low, no err or rty) adds 1 cycle.
- A retry adds 1 BUS cycle plus RETRY_GAP GAP cycles.
- **Back-to-back:** with resp_ready high at edge M, cmd_ready is high during cycle M+1. Sustained throughput is 1 transfer per 3 cycles.
- The response is held indefinitely while resp_ready is low. cmd_valid is ignored outside IDLE.
- cmd_* is sampled only at the handshake edge. The command may change afterwards.

## Test plan
- **Write then read.** Slave is a set/clear register with combinational ack and mode decoded from adr[3:2].
  - Write 0x0000_00A5 to adr 0x0, sel 4'hF: resp_status 0 at N+2.
  - Read adr 0x0: resp_rdata = 0x0000_00A5, status 0.
  - Write 0x0000_0005 to adr 0x8 (clear mode), then read: 0x0000_00A0.
- **Byte lanes.** Write 0xFFFF_FFFF with sel 4'b0010 to a zeroed register, then read: 0x0000_FF00.
- **Retry recovery.** Slave asserts rty on 2 attempts, then ack. Required:
  - 3 BUS periods, each separated by exactly 2 cycles with cyc low.
  - status 0.
  - cmd-to-resp time of 8 cycles.
- **Retry exhaustion and error.**
  - Slave always asserts rty, MAX_RETRIES=3: 4 attempts, then status 3.
  - Slave asserts err and ack together: status 1, resp_rdata 0.
- **Timeout.** Slave never responds, TIMEOUT_CYCLES=255: cyc drops after 255 cycles, status 2, busy is low after the response handshake.
- **Reset and backpressure.**
  - Assert reset_n low during BUS: cyc is 0 within the same cycle, and no response is produced.
  - Hold resp_ready low for 10 cycles: resp_valid, resp_rdata and resp_status are stable, and cmd_ready stays 0.
